// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS decode/control slice: opcode/func constants,
// select encodings and the decoded control word carried from D into EX.
package ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_LUI  = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2
    } npc_op_e;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_HI  = 2'd2,
        SRC_LO  = 2'd3
    } reg_src_e;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Full D-stage decode; only the EX-relevant subset is registered.
    typedef struct packed {
        logic     reg_we;
        logic     mem_we;
        alu_op_e  alu_op;
        logic     alu_src1;
        logic     alu_src2;
        reg_src_e reg_src;
        reg_dst_e reg_dst;
        logic     ext_op;
        logic     is_beq;
        logic     is_bne;
        logic     is_jump;
        logic     rt_used;
        logic     md_op;
        logic     md_read;
    } ctrl_word;

    typedef struct packed {
        logic     reg_we;
        logic     mem_we;
        alu_op_e  alu_op;
        logic     alu_src1;
        logic     alu_src2;
        reg_src_e reg_src;
        reg_dst_e reg_dst;
        logic     md_start;
        logic     illegal;
    } ex_ctrl;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/func decoder. Unknown encodings yield an all-zero
// control word with illegal_o set.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_MD = 1'b1
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output ctrl_word   ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_SPECIAL: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = DST_RD;
                ctrl_o.rt_used = 1'b1;
                case (func_i)
                    FN_ADDU: ctrl_o.alu_op = ALU_ADD;
                    FN_SUBU: ctrl_o.alu_op = ALU_SUB;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    FN_SLTU: ctrl_o.alu_op = ALU_SLTU;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_NOR:  ctrl_o.alu_op = ALU_NOR;
                    FN_XOR:  ctrl_o.alu_op = ALU_XOR;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ctrl_o.reg_we = 1'b0;
                        ctrl_o.md_op  = 1'b1;
                        illegal_o     = !ENABLE_MD;
                    end
                    FN_MFHI: begin
                        ctrl_o.reg_src = SRC_HI;
                        ctrl_o.md_read = 1'b1;
                        illegal_o      = !ENABLE_MD;
                    end
                    FN_MFLO: begin
                        ctrl_o.reg_src = SRC_LO;
                        ctrl_o.md_read = 1'b1;
                        illegal_o      = !ENABLE_MD;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl_o.reg_we   = 1'b1;
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.ext_op   = 1'b1;
                ctrl_o.alu_op   = (opcode_i == OP_ADDIU) ? ALU_ADD :
                                  (opcode_i == OP_SLTI)  ? ALU_SLT : ALU_SLTU;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.reg_we   = 1'b1;
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.alu_op   = (opcode_i == OP_ANDI) ? ALU_AND :
                                  (opcode_i == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                // Source 1 selects the constant shift amount of 16.
                ctrl_o.reg_we   = 1'b1;
                ctrl_o.alu_src1 = 1'b1;
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.alu_op   = ALU_LUI;
            end
            OP_LW: begin
                ctrl_o.reg_we   = 1'b1;
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.ext_op   = 1'b1;
                ctrl_o.reg_src  = SRC_MEM;
            end
            OP_SW: begin
                ctrl_o.mem_we   = 1'b1;
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.ext_op   = 1'b1;
                ctrl_o.rt_used  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.is_beq  = (opcode_i == OP_BEQ);
                ctrl_o.is_bne  = (opcode_i == OP_BNE);
                ctrl_o.ext_op  = 1'b1;
                ctrl_o.rt_used = 1'b1;
            end
            OP_J: ctrl_o.is_jump = 1'b1;
            OP_JAL: begin
                ctrl_o.is_jump = 1'b1;
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = DST_RA;
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            ctrl_o = '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// D-stage control: decode, load-use/branch/MULT-DIV hazard stalls, next-PC
// select, the ID/EX control register and the MULT/DIV busy sequencer.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = 4,
    parameter int NPC_OP_W   = 2,
    parameter int REG_SRC_W  = 2,
    parameter int REG_DST_W  = 2,
    parameter int MD_LATENCY = 4,
    parameter bit ENABLE_MD  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcodeD,
    input  logic [5:0]           funcD,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic                 isRsRtEq,
    input  logic [4:0]           writeRegE,
    output logic                 extOpD,
    output logic [NPC_OP_W-1:0]  npcOpD,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushD,
    output logic                 regWeE,
    output logic                 memWeE,
    output logic [ALU_OP_W-1:0]  aluOpE,
    output logic                 aluSrc1E,
    output logic                 aluSrc2E,
    output logic [REG_SRC_W-1:0] regSrcE,
    output logic [REG_DST_W-1:0] regDstE,
    output logic                 mdStartE,
    output logic                 mdBusy,
    output logic                 illegalE
);

    ctrl_word ctrl_d;
    logic     illegal_d;
    ex_ctrl   ex_d, ex_q;
    npc_op_e  npc_sel;
    logic     load_use, br_haz, md_haz, stall, md_start, fsm_busy;

    ctrl_decoder #(.ENABLE_MD(ENABLE_MD)) u_dec (
        .opcode_i  (opcodeD),
        .func_i    (funcD),
        .ctrl_o    (ctrl_d),
        .illegal_o (illegal_d)
    );

    always_comb begin
        load_use = (ex_q.reg_src == SRC_MEM) && (writeRegE != 5'd0) &&
                   ((writeRegE == rsD) || (ctrl_d.rt_used && (writeRegE == rtD)));
        br_haz   = (ctrl_d.is_beq || ctrl_d.is_bne) && ex_q.reg_we && (writeRegE != 5'd0) &&
                   ((writeRegE == rsD) || (writeRegE == rtD));
        md_haz   = mdBusy && (ctrl_d.md_op || ctrl_d.md_read);
        stall    = load_use || br_haz || md_haz;
        md_start = ctrl_d.md_op && !stall;
    end

    // Branches resolve only on an unstalled cycle, when operands are final.
    always_comb begin
        npc_sel = NPC_PC4;
        if (!stall) begin
            if ((ctrl_d.is_beq && isRsRtEq) || (ctrl_d.is_bne && !isRsRtEq)) begin
                npc_sel = NPC_BRANCH;
            end else if (ctrl_d.is_jump) begin
                npc_sel = NPC_JUMP;
            end
        end
    end

    always_comb begin
        ex_d = '0;
        if (!stall) begin
            ex_d.reg_we   = ctrl_d.reg_we;
            ex_d.mem_we   = ctrl_d.mem_we;
            ex_d.alu_op   = ctrl_d.alu_op;
            ex_d.alu_src1 = ctrl_d.alu_src1;
            ex_d.alu_src2 = ctrl_d.alu_src2;
            ex_d.reg_src  = ctrl_d.reg_src;
            ex_d.reg_dst  = ctrl_d.reg_dst;
            ex_d.md_start = md_start;
            ex_d.illegal  = illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    generate
        if (ENABLE_MD) begin : g_md
            md_state_e  state_d, state_q;
            logic [3:0] cnt_d, cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= MD_IDLE;
                    cnt_q   <= 4'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // cnt counts the remaining busy cycles after the current one.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    MD_IDLE: begin
                        if (md_start) begin
                            state_d = MD_BUSY;
                            cnt_d   = 4'(MD_LATENCY - 1);
                        end
                    end
                    MD_BUSY: begin
                        if (cnt_q == 4'd0) begin
                            state_d = MD_IDLE;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = MD_IDLE;
                        cnt_d   = 4'd0;
                    end
                endcase
            end

            assign fsm_busy = (state_q == MD_BUSY);
        end else begin : g_no_md
            assign fsm_busy = 1'b0;
        end
    endgenerate

    assign mdBusy   = fsm_busy || ex_q.md_start;
    assign stallF   = stall;
    assign stallD   = stall;
    assign npcOpD   = NPC_OP_W'(npc_sel);
    assign flushD   = (npc_sel != NPC_PC4);
    assign extOpD   = ctrl_d.ext_op;
    assign regWeE   = ex_q.reg_we;
    assign memWeE   = ex_q.mem_we;
    assign aluOpE   = ALU_OP_W'(ex_q.alu_op);
    assign aluSrc1E = ex_q.alu_src1;
    assign aluSrc2E = ex_q.alu_src2;
    assign regSrcE  = REG_SRC_W'(ex_q.reg_src);
    assign regDstE  = REG_DST_W'(ex_q.reg_dst);
    assign mdStartE = ex_q.md_start;
    assign illegalE = ex_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed pipeline scenarios plus random traffic,
// checked cycle by cycle against an instruction-level reference model.
module tb_pipe_ctrl_unit;

    localparam int MD_LAT = 4;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_LW = 6'h23, OP_BAD = 6'h3F;
    localparam logic [5:0] F_ADDU = 6'h21, F_MULT = 6'h18, F_DIV = 6'h1A, F_MFLO = 6'h12;

    typedef struct packed {
        logic       we;
        logic       mem;
        logic [3:0] alu;
        logic       s1;
        logic       s2;
        logic [1:0] src;
        logic [1:0] dst;
        logic       ext;
        logic       beq;
        logic       bne;
        logic       jmp;
        logic       rtu;
        logic       mdop;
        logic       mdrd;
        logic       ill;
    } dec_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] npc;
        logic       flush;
        logic       ext;
        logic       we;
        logic       mem;
        logic [3:0] alu;
        logic       s1;
        logic       s2;
        logic [1:0] src;
        logic [1:0] dst;
        logic       mds;
        logic       busy;
        logic       ill;
    } exp_t;

    localparam int W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] opcodeD = '0, funcD = 6'h21;
    logic [4:0] rsD = '0, rtD = '0, writeRegE = '0;
    logic       isRsRtEq = 1'b0;
    logic       extOpD, stallF, stallD, flushD, regWeE, memWeE, aluSrc1E, aluSrc2E;
    logic       mdStartE, mdBusy, illegalE;
    logic [1:0] npcOpD, regSrcE, regDstE;
    logic [3:0] aluOpE;

    pipe_ctrl_unit #(.MD_LATENCY(MD_LAT), .ENABLE_MD(1'b1)) dut (
        .clk(clk), .rst(rst), .opcodeD(opcodeD), .funcD(funcD), .rsD(rsD), .rtD(rtD),
        .isRsRtEq(isRsRtEq), .writeRegE(writeRegE), .extOpD(extOpD), .npcOpD(npcOpD),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .regWeE(regWeE), .memWeE(memWeE),
        .aluOpE(aluOpE), .aluSrc1E(aluSrc1E), .aluSrc2E(aluSrc2E), .regSrcE(regSrcE),
        .regDstE(regDstE), .mdStartE(mdStartE), .mdBusy(mdBusy), .illegalE(illegalE)
    );

    // Second instance with MULT/DIV support removed.
    logic [5:0] op_n = '0, fn_n = 6'h21;
    logic       ext_n, stf_n, std_n, fl_n, we_n, mem_n, s1_n, s2_n, mds_n, busy_n, ill_n;
    logic [1:0] npc_n, src_n, dst_n;
    logic [3:0] alu_n;

    pipe_ctrl_unit #(.MD_LATENCY(MD_LAT), .ENABLE_MD(1'b0)) dut_nomd (
        .clk(clk), .rst(rst), .opcodeD(op_n), .funcD(fn_n), .rsD(5'd0), .rtD(5'd0),
        .isRsRtEq(1'b0), .writeRegE(5'd0), .extOpD(ext_n), .npcOpD(npc_n),
        .stallF(stf_n), .stallD(std_n), .flushD(fl_n), .regWeE(we_n), .memWeE(mem_n),
        .aluOpE(alu_n), .aluSrc1E(s1_n), .aluSrc2E(s2_n), .regSrcE(src_n),
        .regDstE(dst_n), .mdStartE(mds_n), .mdBusy(busy_n), .illegalE(ill_n)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Instruction-level view: what is in EX, and how many busy cycles remain.
    dec_t m_e;
    logic m_mds;
    int   m_md_left;

    function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input bit en_md);
        dec_t d;
        d = '0;
        case (op)
            6'h00: begin
                d.we = 1; d.dst = 2'd1; d.rtu = 1;
                case (fn)
                    6'h21: d.alu = 4'd0;
                    6'h23: d.alu = 4'd1;
                    6'h2A: d.alu = 4'd2;
                    6'h2B: d.alu = 4'd3;
                    6'h24: d.alu = 4'd4;
                    6'h25: d.alu = 4'd5;
                    6'h27: d.alu = 4'd6;
                    6'h26: d.alu = 4'd7;
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin d.we = 0; d.mdop = 1; d.ill = !en_md; end
                    6'h10: begin d.src = 2'd2; d.mdrd = 1; d.ill = !en_md; end
                    6'h12: begin d.src = 2'd3; d.mdrd = 1; d.ill = !en_md; end
                    default: d.ill = 1;
                endcase
            end
            6'h09: begin d.we = 1; d.s2 = 1; d.ext = 1; d.alu = 4'd0; end
            6'h0A: begin d.we = 1; d.s2 = 1; d.ext = 1; d.alu = 4'd2; end
            6'h0B: begin d.we = 1; d.s2 = 1; d.ext = 1; d.alu = 4'd3; end
            6'h0C: begin d.we = 1; d.s2 = 1; d.alu = 4'd4; end
            6'h0D: begin d.we = 1; d.s2 = 1; d.alu = 4'd5; end
            6'h0E: begin d.we = 1; d.s2 = 1; d.alu = 4'd7; end
            6'h0F: begin d.we = 1; d.s1 = 1; d.s2 = 1; d.alu = 4'd8; end
            6'h23: begin d.we = 1; d.s2 = 1; d.ext = 1; d.src = 2'd1; end
            6'h2B: begin d.mem = 1; d.s2 = 1; d.ext = 1; d.rtu = 1; end
            6'h04: begin d.beq = 1; d.ext = 1; d.rtu = 1; end
            6'h05: begin d.bne = 1; d.ext = 1; d.rtu = 1; end
            6'h02: d.jmp = 1;
            6'h03: begin d.jmp = 1; d.we = 1; d.dst = 2'd2; end
            default: d.ill = 1;
        endcase
        if (d.ill) begin
            d = '0;
            d.ill = 1;
        end
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic eq, input logic [4:0] wre, input logic r);
        dec_t d;
        exp_t e;
        logic lu, bh, mh, st;
        logic [1:0] npc;
        @(posedge clk);
        #1;
        opcodeD = op; funcD = fn; rsD = rs; rtD = rt; isRsRtEq = eq; writeRegE = wre; rst = r;
        d  = ref_decode(op, fn, 1'b1);
        lu = (m_e.src == 2'd1) && wre != 0 && (wre == rs || (d.rtu && wre == rt));
        bh = (d.beq || d.bne) && m_e.we && wre != 0 && (wre == rs || wre == rt);
        mh = (m_md_left > 0) && (d.mdop || d.mdrd);
        st = lu || bh || mh;
        npc = 2'd0;
        if (!st) begin
            if ((d.beq && eq) || (d.bne && !eq)) npc = 2'd1;
            else if (d.jmp) npc = 2'd2;
        end
        e.stall = st; e.npc = npc; e.flush = (npc != 0); e.ext = d.ext;
        e.we = m_e.we; e.mem = m_e.mem; e.alu = m_e.alu; e.s1 = m_e.s1; e.s2 = m_e.s2;
        e.src = m_e.src; e.dst = m_e.dst; e.mds = m_mds; e.busy = (m_md_left > 0); e.ill = m_e.ill;
        exp_q.push_back(e);
        if (r) begin
            m_e = '0; m_mds = 0; m_md_left = 0;
        end else if (st) begin
            m_e = '0; m_mds = 0;
            if (m_md_left > 0) m_md_left--;
        end else begin
            m_e = d; m_mds = d.mdop;
            if (d.mdop) m_md_left = MD_LAT;
            else if (m_md_left > 0) m_md_left--;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stallF", 4'(stallF), 4'(e.stall));
                chk("stallD", 4'(stallD), 4'(e.stall));
                chk("npcOpD", 4'(npcOpD), 4'(e.npc));
                chk("flushD", 4'(flushD), 4'(e.flush));
                chk("extOpD", 4'(extOpD), 4'(e.ext));
                chk("regWeE", 4'(regWeE), 4'(e.we));
                chk("memWeE", 4'(memWeE), 4'(e.mem));
                chk("aluOpE", aluOpE, e.alu);
                chk("aluSrc1E", 4'(aluSrc1E), 4'(e.s1));
                chk("aluSrc2E", 4'(aluSrc2E), 4'(e.s2));
                chk("regSrcE", 4'(regSrcE), 4'(e.src));
                chk("regDstE", 4'(regDstE), 4'(e.dst));
                chk("mdStartE", 4'(mdStartE), 4'(e.mds));
                chk("mdBusy", 4'(mdBusy), 4'(e.busy));
                chk("illegalE", 4'(illegalE), 4'(e.ill));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [5:0] op_pool [0:17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                   6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    logic [5:0] fn_pool [0:15] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h27, 6'h26,
                                   6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h00, 6'h3F};

    initial begin
        m_e = '0; m_mds = 0; m_md_left = 0;
        repeat (2) @(posedge clk);

        drive(OP_R, F_ADDU, 0, 0, 0, 0, 1);
        // load-use on $8
        drive(OP_LW, 0, 1, 8, 0, 0, 0);
        drive(OP_R, F_ADDU, 8, 2, 0, 8, 0);
        drive(OP_R, F_ADDU, 8, 2, 0, 0, 0);
        drive(OP_R, F_ADDU, 0, 0, 0, 3, 0);
        // branches without hazard
        drive(OP_BEQ, 0, 1, 1, 1, 0, 0);
        drive(OP_BNE, 0, 1, 1, 1, 0, 0);
        drive(OP_BNE, 0, 1, 2, 0, 0, 0);
        // branch-compare hazard on $9
        drive(OP_R, F_ADDU, 1, 2, 0, 0, 0);
        drive(OP_BEQ, 0, 9, 1, 1, 9, 0);
        drive(OP_BEQ, 0, 9, 1, 1, 0, 0);
        // DIV then MFLO
        drive(OP_R, F_DIV, 1, 2, 0, 0, 0);
        repeat (6) drive(OP_R, F_MFLO, 0, 0, 0, 0, 0);
        drive(OP_R, F_ADDU, 0, 0, 0, 0, 0);
        // illegal opcode
        drive(OP_BAD, 0, 0, 0, 0, 0, 0);
        drive(OP_R, F_ADDU, 0, 0, 0, 0, 0);
        // reset while the unit is busy with two cycles left
        drive(OP_R, F_DIV, 1, 2, 0, 0, 0);
        drive(OP_R, F_MFLO, 0, 0, 0, 0, 0);
        drive(OP_R, F_MFLO, 0, 0, 0, 0, 1);
        drive(OP_JAL, 0, 0, 0, 0, 0, 0);
        drive(OP_J, 0, 0, 0, 0, 0, 0);
        drive(OP_R, F_ADDU, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive(op_pool[$urandom_range(0, 17)], fn_pool[$urandom_range(0, 15)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 49) == 0));
        end
        drive(OP_R, F_ADDU, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        // MULT is illegal when the MULT/DIV unit is removed.
        @(posedge clk); #1;
        op_n = OP_R; fn_n = F_MULT;
        chk("nomd_stall", 4'(stf_n), 4'd0);
        @(posedge clk); #1;
        fn_n = F_ADDU;
        chk("nomd_illegalE", 4'(ill_n), 4'd1);
        chk("nomd_regWeE", 4'(we_n), 4'd0);
        chk("nomd_mdStartE", 4'(mds_n), 4'd0);
        chk("nomd_mdBusy", 4'(busy_n), 4'd0);
        @(posedge clk); #1;
        chk("nomd_addu_illegalE", 4'(ill_n), 4'd0);
        chk("nomd_addu_regWeE", 4'(we_n), 4'd1);
        chk("nomd_addu_regDstE", 4'(dst_n), 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Second-generation decode/control block for the 5-stage MIPS pipeline.
- Decodes the D-stage instruction, resolves branches using `isRsRtEq`, and drives the ID/EX control register.
- Detects load-use and branch-compare hazards, then issues stall and flush signals.
- Sequences the multi-cycle MULT/DIV unit with a busy counter.
- Width and latency are parametrised; an unknown opcode becomes a NOP bubble and is flagged.

Parameters:
- ALU_OP_W, 4, ALU operation code width
- NPC_OP_W, 2, next-PC select width
- REG_SRC_W, 2, writeback source select width
- REG_DST_W, 2, destination register select width
- MD_LATENCY, 4, cycles the MULT/DIV unit is busy; legal range 1..15
- ENABLE_MD, 1, 0 = MULT/DIV/MFHI/MFLO decode as illegal and the FSM is removed

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- opcodeD  in  6  D-stage instruction [31:26]
- funcD  in  6  D-stage instruction [5:0]
- rsD  in  5  D-stage rs field
- rtD  in  5  D-stage rt field
- isRsRtEq  in  1  D-stage comparator result, rs == rt
- writeRegE  in  5  destination register of the instruction in EX, from the datapath
- extOpD  out  1  sign (1) / zero (0) extend select for the D-stage immediate; combinational
- npcOpD  out  NPC_OP_W  0 = PC+4, 1 = branch target, 2 = jump target; combinational
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID
- flushD  out  1  clear IF/ID (taken branch or jump)
- regWeE  out  1  registered EX control: register-file write enable
- memWeE  out  1  registered EX control: data-memory write enable
- aluOpE  out  ALU_OP_W  registered EX control: ALU operation
- aluSrc1E  out  1  registered EX control: ALU source 1 select
- aluSrc2E  out  1  registered EX control: ALU source 2 select
- regSrcE  out  REG_SRC_W  registered EX control: writeback source; 0 = ALU, 1 = MEM, 2 = HI, 3 = LO
- regDstE  out  REG_DST_W  registered EX control: 0 = rt, 1 = rd, 2 = $31
- mdStartE  out  1  one-cycle start pulse to the MULT/DIV unit, aligned with the EX stage
- mdBusy  out  1  MULT/DIV unit is busy
- illegalE  out  1  the instruction now in EX was an unknown opcode/func

Behaviour:
Decode (combinational):
- Supports ADDU, SUBU, SLT, SLTU, AND, OR, NOR, XOR, ADDIU, SLTI, SLTIU, LUI, ANDI, ORI, XORI, LW, SW, BEQ, BNE, J, JAL.
- When ENABLE_MD = 1, also supports MULT, MULTU, DIV, DIVU, MFHI, MFLO.
- Any other encoding decodes to an all-zero control word with `illegal` = 1.
- Decoded result is the internal word ctrlD.

Hazards (combinational):
- loadUse = (regSrcE == MEM) && writeRegE != 0 && (writeRegE == rsD || (rtUsedD && writeRegE == rtD)).
  - rtUsedD is true for R-type, BEQ/BNE and SW.
- brHaz = BEQ/BNE in D && regWeE && writeRegE != 0 && writeRegE matches rsD or rtD.
- mdHaz = mdBusy && D holds MULT/DIV/MFHI/MFLO.
- stall = loadUse || brHaz || mdHaz. Then stallF = stallD = stall.

Next PC:
- While stall = 1: npcOpD = 0 and flushD = 0. A branch is never taken while stalled.
- While not stalled:
  - BEQ with isRsRtEq = 1, or BNE with isRsRtEq = 0: npcOpD = 1.
  - J / JAL: npcOpD = 2.
  - Otherwise npcOpD = 0.
- flushD = 1 whenever npcOpD != 0.

ID/EX register:
- rst, or stall = 1: all E outputs (including illegalE and mdStartE) load 0, i.e. a bubble.
- Otherwise they load ctrlD.
- JAL produces regWeE = 1 and regDstE = 2.

MD FSM, states IDLE / BUSY, counter cnt of 4 bits:
- IDLE → BUSY when D holds MULT/DIV and stall = 0.
  - cnt loads MD_LATENCY-1.
  - mdStartE = 1 on the next cycle.
- BUSY: cnt decrements each cycle. At cnt == 0, go to IDLE on the next edge.
- mdBusy = 1 in BUSY, and also in the cycle mdStartE = 1.
- A new MD instruction or MFHI/MFLO stalls until the unit returns to IDLE.
- With MD_LATENCY = 1, mdBusy is high for exactly one cycle.

Priority and reset:
- Priority: rst > stall > normal update.
- Reset mid-BUSY: the FSM returns to IDLE and cnt = 0 immediately at the edge.
- All registered outputs reset to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode and func constants;
  - ALU op, NPC op, REG_SRC and REG_DST encodings;
  - a packed ctrl_word typedef.
- Sub-module ctrl_decoder: purely combinational opcode/func → ctrl_word plus illegal.
- The top level holds the hazard logic, the ID/EX register and the MD FSM.

Test Plan:
1. Load-use: LW with writeRegE = 8, next ADDU with rsD = 8 → stallF = stallD = 1 for one cycle; the next-cycle E outputs are all 0; ADDU then issues with regDstE = 1.
2. Branch: BEQ with isRsRtEq = 1 and no hazard → npcOpD = 1, flushD = 1. BNE with isRsRtEq = 1 → npcOpD = 0, flushD = 0.
3. Branch hazard: ADDU writing $9 in EX (regWeE = 1, writeRegE = 9), BEQ rsD = 9 in D → stall = 1 and npcOpD = 0; the following cycle resolves normally.
4. MD: MD_LATENCY = 4, DIV issued, then MFLO next → mdStartE pulses once; mdBusy is high 4 cycles; MFLO stalls until IDLE, then regSrcE = 3.
5. Illegal: opcode 6'h3F → E outputs all 0 and illegalE = 1 for one cycle. With ENABLE_MD = 0, MULT is also illegal.
6. Reset mid-BUSY: assert rst at cnt = 2 → the next cycle has mdBusy = 0, all E outputs 0, stallF = 0; a JAL after reset gives regWeE = 1, regDstE = 2, npcOpD = 2.
